// File: rtl/btu_pkg.sv
// ----------------------------------------------------------------------------
// btu_pkg
// Shared types and constants for the branch target unit.
//   mode_t      : control-transfer kind carried alongside each request
//   LINK_OFFSET : distance from the instruction PC to the return address
// ----------------------------------------------------------------------------
package btu_pkg;

    typedef enum logic [1:0] {
        MODE_JALR   = 2'b00,
        MODE_JAL    = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    localparam int LINK_OFFSET = 4;

endpackage

// File: rtl/btu_pipe_reg.sv
// ----------------------------------------------------------------------------
// btu_pipe_reg
// One valid/ready pipeline stage: a valid flag plus a W-bit payload register.
// Ports:
//   clk      in   1  core clock, rising edge
//   rst      in   1  asynchronous reset, active-low
//   flush    in   1  synchronous kill of the valid flag (highest priority)
//   load     in   1  capture in_data and mark the stage valid
//   drain    in   1  the downstream consumer takes the current entry
//   in_data  in   W  payload to capture
//   valid    out  1  stage holds a live entry
//   out_data out  W  captured payload
// ----------------------------------------------------------------------------
module btu_pipe_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] in_data,
    output logic         valid,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Payload is only rewritten on load and is never cleared by flush;
    // a flushed stage simply loses its valid flag.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            data_d = in_data;
        end
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid    = valid_q;
    assign out_data = data_q;

endmodule

// File: rtl/branch_target_unit.sv
// ----------------------------------------------------------------------------
// branch_target_unit
// Two-stage pipelined JAL/JALR/branch target and link-address generator with
// a valid/ready handshake and a synchronous flush.
// Optional feature macro: BTU_MISALIGN_CHECK_EN (adds out_misalign).
// Ports:
//   clk          in   1     core clock, rising edge
//   rst          in   1     asynchronous reset, active-low
//   flush        in   1     kill all in-flight requests (and a same-cycle accept)
//   in_valid     in   1     request valid
//   in_ready     out  1     request accepted when in_valid && in_ready
//   in_mode      in   2     btu_pkg::mode_t encoding
//   in_pc        in   XLEN  PC of the control-transfer instruction
//   in_rs1       in   XLEN  rs1 operand (JALR base)
//   in_imm       in   XLEN  sign-extended immediate
//   out_valid    out  1     result valid
//   out_ready    in   1     consumer accepts when out_valid && out_ready
//   out_target   out  XLEN  target address
//   out_link     out  XLEN  in_pc + 4
//   out_mode     out  2     mode carried with the result
//   out_misalign out  1     target not IALIGN-aligned (macro builds only)
// ----------------------------------------------------------------------------
module branch_target_unit
    import btu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_link,
`ifdef BTU_MISALIGN_CHECK_EN
    output logic            out_misalign,
`endif
    output logic [1:0]      out_mode
);

    // Reject unsupported configurations at elaboration time.
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("branch_target_unit: XLEN must be 32 or 64");
    end
    if (IALIGN != 32 && IALIGN != 16) begin : g_bad_ialign
        $error("branch_target_unit: IALIGN must be 32 or 16");
    end

    localparam int S1W = 2 * XLEN + 2;
`ifdef BTU_MISALIGN_CHECK_EN
    localparam int S2W = 2 * XLEN + 3;
`else
    localparam int S2W = 2 * XLEN + 2;
`endif

    logic            s1_valid, s2_valid;
    logic            s1_load, s2_load;
    logic [S1W-1:0]  s1_in, s1_out;
    logic [S2W-1:0]  s2_in, s2_out;
    logic [XLEN-1:0] base, sum, link;
    logic [XLEN-1:0] s1_sum, s1_link, target;
    mode_t           in_mode_e, s1_mode;

    // Accept whenever either stage has room or the whole pipe is moving.
    // Stage 2 takes stage 1's entry whenever it is empty or being drained.
    assign in_ready = !s1_valid || !s2_valid || out_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid && (!s2_valid || out_ready);

    // Stage 1 inputs: JALR adds to rs1, every other mode (including the
    // reserved encoding) adds to the PC. Carry-out is discarded.
    always_comb begin
        in_mode_e = mode_t'(in_mode);
        base      = (in_mode_e == MODE_JALR) ? in_rs1 : in_pc;
        sum       = base + in_imm;
        link      = in_pc + XLEN'(LINK_OFFSET);
        s1_in     = {in_mode, link, sum};
    end

    btu_pipe_reg #(.W(S1W)) u_stage1 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .load     (s1_load),
        .drain    (s2_load),
        .in_data  (s1_in),
        .valid    (s1_valid),
        .out_data (s1_out)
    );

    // Stage 2 inputs: JALR targets have bit 0 cleared after the add.
    always_comb begin
        s1_mode = mode_t'(s1_out[S1W-1 -: 2]);
        s1_link = s1_out[2*XLEN-1 -: XLEN];
        s1_sum  = s1_out[XLEN-1:0];
        target  = s1_sum;
        if (s1_mode == MODE_JALR) begin
            target[0] = 1'b0;
        end
`ifdef BTU_MISALIGN_CHECK_EN
        // With 16-bit alignment no reachable target can be misaligned.
        s2_in = {((IALIGN == 32) ? target[1] : 1'b0), s1_out[S1W-1 -: 2], s1_link, target};
`else
        s2_in = {s1_out[S1W-1 -: 2], s1_link, target};
`endif
    end

    btu_pipe_reg #(.W(S2W)) u_stage2 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .load     (s2_load),
        .drain    (out_ready),
        .in_data  (s2_in),
        .valid    (s2_valid),
        .out_data (s2_out)
    );

    assign out_valid  = s2_valid;
    assign out_target = s2_out[XLEN-1:0];
    assign out_link   = s2_out[2*XLEN-1 -: XLEN];
    assign out_mode   = s2_out[2*XLEN+1 -: 2];
`ifdef BTU_MISALIGN_CHECK_EN
    assign out_misalign = s2_out[S2W-1];
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_target_unit
// Directed scenarios followed by randomized traffic, all checked against an
// in-order queue of predicted results. A request joins the queue when it is
// accepted, leaves it when the consumer takes it, and a flush empties it.
// ----------------------------------------------------------------------------
module tb_branch_target_unit;

    localparam int XLEN   = 32;
    localparam int IALIGN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_mode;
    logic [XLEN-1:0] in_pc, in_rs1, in_imm;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_target, out_link;
    logic [1:0]      out_mode;
`ifdef BTU_MISALIGN_CHECK_EN
    logic            out_misalign;
`endif

    int total = 0;
    int bad   = 0;
    int edgeCount = 0;

    typedef struct {
        logic [31:0] target;
        logic [31:0] link;
        logic [1:0]  mode;
        logic        mis;
        int          acceptEdge;
    } expect_t;

    expect_t modelQ[$];

    branch_target_unit #(.XLEN(XLEN), .IALIGN(IALIGN)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_pc      (in_pc),
        .in_rs1     (in_rs1),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_target (out_target),
        .out_link   (out_link),
`ifdef BTU_MISALIGN_CHECK_EN
        .out_misalign (out_misalign),
`endif
        .out_mode   (out_mode)
    );

    always #5 clk = ~clk;

    // Reference result straight from the architectural rules.
    function automatic expect_t predict(logic [1:0] mode, logic [31:0] pc,
                                        logic [31:0] rs1, logic [31:0] imm, int accEdge);
        expect_t e;
        logic [31:0] t;
        if (mode == 2'b00) begin
            t = rs1 + imm;
            t = t & 32'hFFFF_FFFE;
        end else begin
            t = pc + imm;
        end
        e.target     = t;
        e.link       = pc + 32'd4;
        e.mode       = mode;
        e.mis        = (IALIGN == 32) ? t[1] : 1'b0;
        e.acceptEdge = accEdge;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic modelOutValid();
        return (modelQ.size() > 0) && (modelQ[0].acceptEdge < edgeCount);
    endfunction

    // Compare the result port against the head of the prediction queue.
    task automatic checkResult();
        logic expValid;
        expValid = modelOutValid();
        checkOutput("out_valid", out_valid, expValid);
        if (expValid) begin
            checkOutput("out_target", out_target, modelQ[0].target);
            checkOutput("out_link", out_link, modelQ[0].link);
            checkOutput("out_mode", out_mode, modelQ[0].mode);
`ifdef BTU_MISALIGN_CHECK_EN
            checkOutput("out_misalign", out_misalign, modelQ[0].mis);
`endif
        end
    endtask

    // Drive one cycle of inputs, check in_ready, clock, update model, check outputs.
    task automatic applyStimulus(input logic v, input logic [1:0] mode, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] imm,
                                 input logic oready, input logic fl);
        logic expReady, acc, outHs;
        in_valid  = v;
        in_mode   = mode;
        in_pc     = pc;
        in_rs1    = rs1;
        in_imm    = imm;
        out_ready = oready;
        flush     = fl;
        #1;
        expReady = (modelQ.size() < 2) || oready;
        checkOutput("in_ready", in_ready, expReady);
        acc   = v && expReady;
        outHs = modelOutValid() && oready;
        @(posedge clk);
        edgeCount++;
        if (fl) begin
            modelQ.delete();
        end else begin
            if (outHs) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(predict(mode, pc, rs1, imm, edgeCount));
        end
        #1;
        checkResult();
    endtask

    task automatic idle(input logic oready);
        applyStimulus(1'b0, 2'b01, 32'h0, 32'h0, 32'h0, oready, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_mode = 2'b00;
        in_pc = '0;
        in_rs1 = '0;
        in_imm = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_target", out_target, 32'h0);
        checkOutput("reset_out_link", out_link, 32'h0);
        checkOutput("reset_out_mode", out_mode, 2'b00);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        rst = 1'b1;

        // JAL: result appears after two registered stages.
        applyStimulus(1'b1, 2'b01, 32'h100, 32'h0, 32'h20, 1'b1, 1'b0);
        checkOutput("t1_not_yet", out_valid, 1'b0);
        idle(1'b1);
        checkOutput("t1_valid", out_valid, 1'b1);
        checkOutput("t1_target", out_target, 32'h120);
        checkOutput("t1_link", out_link, 32'h104);
        checkOutput("t1_mode", out_mode, 2'b01);
        idle(1'b1);

        // JALR: bit 0 cleared, bit 1 set.
        applyStimulus(1'b1, 2'b00, 32'h40, 32'h1003, 32'h4, 1'b1, 1'b0);
        idle(1'b1);
        checkOutput("t2_target", out_target, 32'h1006);
`ifdef BTU_MISALIGN_CHECK_EN
        checkOutput("t2_misalign", out_misalign, 1'b1);
`endif
        idle(1'b1);

        // Back-to-back stream, then a backpressure stall.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'(i % 3), 32'h200 + 32'(4 * i), $urandom, $urandom, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'b10, 32'h300 + 32'(4 * i), 32'h0, 32'h8, 1'b0, 1'b0);
        end
        checkOutput("t3_in_ready_stalled", in_ready, 1'b0);
        repeat (3) idle(1'b1);

        // Flush with both stages full and a request on the input.
        applyStimulus(1'b1, 2'b01, 32'h400, 32'h0, 32'h10, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 32'h404, 32'h0, 32'h10, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 32'h408, 32'h0, 32'h10, 1'b0, 1'b1);
        checkOutput("t4_flushed", out_valid, 1'b0);
        repeat (3) idle(1'b1);

        // Modulo wrap of both the target and the link.
        applyStimulus(1'b1, 2'b10, 32'hFFFF_FFF8, 32'h0, 32'h10, 1'b1, 1'b0);
        idle(1'b1);
        checkOutput("t5_target", out_target, 32'h0000_0008);
        checkOutput("t5_link", out_link, 32'hFFFF_FFFC);

        // Asynchronous reset while a result is pending.
        applyStimulus(1'b1, 2'b01, 32'h500, 32'h0, 32'h4, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t6_pre_valid", out_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_valid", out_valid, 1'b0);
        checkOutput("t6_rst_target", out_target, 32'h0);
        modelQ.delete();
        @(posedge clk);
        edgeCount++;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_in_ready", in_ready, 1'b1);
        @(posedge clk);
        edgeCount++;
        #1;

        // Randomized traffic with backpressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                          $urandom, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end
        repeat (4) idle(1'b1);
        checkOutput("final_drained", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
